// File: rtl/nrzi_toggle_decoder_if.sv
// Bit-level line input and word-level output of the NRZI toggle decoder.
// Master drives the line and strobe; slave is the decoder.
interface nrzi_toggle_decoder_if #(
  parameter int WIDTH = 8
) ();
  logic             bit_en;
  logic             line_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             in_frame;
  logic             frame_done;

  modport master (
    output bit_en,
    output line_in,
    input  data_out,
    input  data_valid,
    input  in_frame,
    input  frame_done
  );

  modport slave (
    input  bit_en,
    input  line_in,
    output data_out,
    output data_valid,
    output in_frame,
    output frame_done
  );
endinterface

// File: rtl/nrzi_toggle_decoder.sv
// NRZI toggle-line receiver: decodes toggles to bits, hunts for a sync
// word, then deserializes a fixed number of MSB-first data words.
module nrzi_toggle_decoder #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = 'hA5,
  parameter int               WORDS = 4
) (
  input logic                  clk,
  input logic                  reset,
  nrzi_toggle_decoder_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = $clog2(WORDS) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

  typedef enum logic {
    HUNT,
    RECV
  } state_e;

  state_e           state_q, state_d;
  logic             line_prev_q, line_prev_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]    word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             in_frame_q, in_frame_d;
  logic             frame_done_q, frame_done_d;
  logic             d;
  logic [WIDTH-1:0] sr_nx;

  // Next-state: decode one bit per strobe, then hunt or assemble.
  always_comb begin
    state_d      = state_q;
    line_prev_d  = line_prev_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    d            = bus.line_in ^ line_prev_q;
    sr_nx        = {sr_q, d};
    if (bus.bit_en) begin
      line_prev_d = bus.line_in;
      sr_d        = sr_nx[WIDTH-2:0];
      unique case (state_q)
        HUNT: begin
          if (sr_nx == SYNC) begin
            state_d    = RECV;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        RECV: begin
          if (bit_cnt_q == BIT_LAST) begin
            data_out_d   = sr_nx;
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            word_cnt_d   = word_cnt_q + 1'b1;
            if (word_cnt_q == WORD_LAST) begin
              frame_done_d = 1'b1;
              state_d      = HUNT;
              sr_d         = '0;
              word_cnt_d   = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    in_frame_d = (state_d == RECV);
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      line_prev_q  <= 1'b0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_prev_q  <= line_prev_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      in_frame_q   <= in_frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.in_frame   = in_frame_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_nrzi_toggle_decoder.sv
// Bench for nrzi_toggle_decoder: directed frames plus random line traffic,
// checked every cycle against a bit-queue model of the receiver.
module tb_nrzi_toggle_decoder;
  localparam int         W  = 8;
  localparam logic [7:0] SY = 8'hA5;
  localparam int         NW = 4;

  logic clk = 1'b0;
  logic rst_n;

  nrzi_toggle_decoder_if #(.WIDTH(W)) bus ();

  nrzi_toggle_decoder #(
    .WIDTH(W),
    .SYNC (SY),
    .WORDS(NW)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  bit           m_prev;
  int           m_hunt;
  bit           m_bits[$];
  bit           m_recv;
  int           m_words;
  logic [W-1:0] e_dout;
  bit           e_dv;
  bit           e_fd;
  logic [W-1:0] mlog[$];
  bit           tx;
  logic [W-1:0] fw[NW];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_prev  = 1'b0;
    m_hunt  = 0;
    m_bits.delete();
    m_recv  = 1'b0;
    m_words = 0;
    e_dout  = '0;
    e_dv    = 1'b0;
    e_fd    = 1'b0;
  endfunction

  function automatic void model_step(bit be, bit ln);
    bit d;
    int w;
    e_dv = 1'b0;
    e_fd = 1'b0;
    if (!be) return;
    d      = ln ^ m_prev;
    m_prev = ln;
    if (!m_recv) begin
      m_hunt = (m_hunt * 2 + int'(d)) % (1 << W);
      if (m_hunt == int'(SY)) begin
        m_recv  = 1'b1;
        m_words = 0;
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == W) begin
        w = 0;
        foreach (m_bits[i]) w = w * 2 + int'(m_bits[i]);
        m_bits.delete();
        e_dout = W'(w);
        e_dv   = 1'b1;
        mlog.push_back(W'(w));
        m_words++;
        if (m_words == NW) begin
          e_fd    = 1'b1;
          m_recv  = 1'b0;
          m_hunt  = 0;
          m_words = 0;
        end
      end
    end
  endfunction

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("data_out",   32'(bus.data_out),   32'(e_dout));
      chk("data_valid", 32'(bus.data_valid), 32'(e_dv));
      chk("in_frame",   32'(bus.in_frame),   32'(m_recv));
      chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    end
  end

  task automatic tick(bit be, bit b);
    bus.bit_en = be;
    if (be) tx = tx ^ b;
    bus.line_in = tx;
    @(posedge clk);
    if (rst_n) model_step(be, bus.line_in);
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(logic [W-1:0] v, int gap);
    for (int i = W - 1; i >= 0; i--) begin
      tick(1'b1, v[i]);
      repeat (gap) tick(1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(int gap);
    send_word(SY, gap);
    for (int i = 0; i < NW; i++) send_word(fw[i], gap);
  endtask

  task automatic chk_frame(string nm);
    chk($sformatf("%s count", nm), 32'(mlog.size()), 32'(NW));
    for (int i = 0; i < NW; i++)
      if (i < mlog.size())
        chk($sformatf("%s word%0d", nm, i), 32'(mlog[i]), 32'(fw[i]));
    mlog.delete();
  endtask

  initial begin
    logic [11:0] pat;
    rst_n       = 1'b0;
    bus.bit_en  = 1'b0;
    bus.line_in = 1'b0;
    tx          = 1'b0;
    model_reset();
    #2 bus.line_in = 1'b1;
    #2 bus.line_in = 1'b0;
    #2 bus.line_in = 1'b1;
    #2 bus.line_in = 1'b0;
    #2 bus.line_in = 1'b1;
    #1;
    chk("rst data_out",   32'(bus.data_out),   32'h0);
    chk("rst data_valid", 32'(bus.data_valid), 32'h0);
    chk("rst in_frame",   32'(bus.in_frame),   32'h0);
    chk("rst frame_done", 32'(bus.frame_done), 32'h0);
    bus.line_in = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    repeat (16) tick(1'b1, 1'b0);
    chk("idle in_frame", 32'(bus.in_frame), 32'h0);

    // sync plus four words, continuous strobe
    mlog.delete();
    send_word(SY, 0);
    chk("sync in_frame", 32'(bus.in_frame), 32'h1);
    fw = '{8'h01, 8'h80, 8'hFF, 8'h00};
    for (int i = 0; i < NW; i++) send_word(fw[i], 0);
    chk("last frame_done", 32'(bus.frame_done), 32'h1);
    chk("last data_valid", 32'(bus.data_valid), 32'h1);
    chk("end in_frame",    32'(bus.in_frame),   32'h0);
    chk("last data_out",   32'(bus.data_out),   32'h00);
    chk_frame("basic");

    // sync pattern as payload
    fw = '{8'hA5, 8'h12, 8'hA5, 8'h34};
    send_frame(0);
    chk("syncdata in_frame", 32'(bus.in_frame), 32'h0);
    chk_frame("syncdata");

    // throttled strobe
    fw = '{8'h01, 8'h80, 8'hFF, 8'h00};
    send_frame(2);
    chk_frame("throttle");

    // reset mid-frame after 5 bits of word 2
    send_word(SY, 0);
    send_word(8'h3C, 0);
    for (int i = W - 1; i > W - 6; i--) tick(1'b1, 1'(8'h96 >> i));
    mlog.delete();
    #2 rst_n = 1'b0;
    model_reset();
    tx          = 1'b0;
    bus.line_in = 1'b0;
    #1;
    chk("mid rst data_out", 32'(bus.data_out),   32'h0);
    chk("mid rst in_frame", 32'(bus.in_frame),   32'h0);
    chk("mid rst valid",    32'(bus.data_valid), 32'h0);
    bus.bit_en = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    fw = '{8'hC3, 8'h5A, 8'hA5, 8'h7E};
    send_frame(0);
    chk_frame("post rst");

    // overlapping sync candidates
    pat = 12'h5A5;
    for (int i = 11; i >= 1; i--) tick(1'b1, pat[i]);
    chk("overlap early", 32'(bus.in_frame), 32'h0);
    tick(1'b1, pat[0]);
    chk("overlap lock", 32'(bus.in_frame), 32'h1);
    for (int i = 0; i < NW; i++) fw[i] = W'($urandom);
    for (int i = 0; i < NW; i++) send_word(fw[i], 0);
    chk_frame("overlap");

    // random traffic with occasional sync injection
    repeat (3000) begin
      if ($urandom_range(0, 99) == 0) send_word(SY, 0);
      else if ($urandom_range(0, 9) < 3) tick(1'b0, 1'b0);
      else tick(1'b1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
